// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_pkg
// Description : Shared types and constants for the data-memory arbiter.
//               - FSM state encoding
//               - requester port identifiers
//               - byte-to-word shift
//               - address error check helper
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic        c_PORT_CPU   = 1'b0;
  localparam logic        c_PORT_DMA   = 1'b1;
  localparam int unsigned c_WORD_SHIFT = 3;

  // A request is in error when it is not 8-byte aligned, or when its word
  // index falls beyond the end of the memory.
  function automatic logic addr_err(input logic [63:0] addr,
                                    input int unsigned words);
    logic [63-c_WORD_SHIFT:0] w_index;
    w_index  = addr[63:c_WORD_SHIFT];
    addr_err = (addr[c_WORD_SHIFT-1:0] != '0) ||
               (w_index >= (64-c_WORD_SHIFT)'(words));
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester arbiter, round-robin or fixed priority.
//               Ports:
//                 i_req[1:0]    requests (bit 0 = cpu, bit 1 = dma)
//                 i_last_grant  port id granted most recently
//                 o_grant[1:0]  one-hot grant (zero when no request)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
  import dmem_arbiter_pkg::*;
#(
  parameter int FIXED_PRI = 0
) (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11: begin
        // On a tie the port that did not win last time goes first, unless
        // the cpu is configured to always win.
        if ((FIXED_PRI != 0) || (i_last_grant == c_PORT_DMA)) begin
          o_grant = 2'b01;
        end else begin
          o_grant = 2'b10;
        end
      end
      default: o_grant = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares a single-port data memory between the pipeline MEM
//               stage (cpu) and a debug/DMA loader (dma).
//               Ports:
//                 clk, reset              clock, async active-high reset
//                 cpu_req_* / dma_req_*   valid/ready request channels
//                 cpu_rsp_* / dma_rsp_*   one-cycle response pulses
//                 mem_*                   data_memory interface
//               One transaction every two cycles: accept -> ACCESS -> RESP,
//               with the next accept allowed in the RESP cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int FIXED_PRI = 0,
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req_valid,
  input  logic        cpu_req_write,
  input  logic [63:0] cpu_req_addr,
  input  logic [63:0] cpu_req_wdata,
  output logic        cpu_req_ready,
  output logic        cpu_rsp_valid,
  output logic [63:0] cpu_rsp_rdata,
  output logic        cpu_rsp_err,
  input  logic        dma_req_valid,
  input  logic        dma_req_write,
  input  logic [63:0] dma_req_addr,
  input  logic [63:0] dma_req_wdata,
  output logic        dma_req_ready,
  output logic        dma_rsp_valid,
  output logic [63:0] dma_rsp_rdata,
  output logic        dma_rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_address,
  output logic [63:0] mem_write_data,
  input  logic [63:0] mem_read_data
);

  state_t      r_state;
  state_t      w_next_state;
  logic        r_last_grant;
  logic        r_port;
  logic        r_write;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic        r_err;
  logic [63:0] r_rdata;

  logic [1:0]  w_grant;
  logic        w_can_accept;
  logic        w_accept;
  logic        w_sel_dma;
  logic        w_sel_write;
  logic [63:0] w_sel_addr;
  logic [63:0] w_sel_wdata;
  logic        w_sel_err;
  logic        w_in_access;
  logic        w_in_resp;

  // --------------------------------------------------------------------------
  // Arbitration and acceptance
  // --------------------------------------------------------------------------
  rr_arb2 #(
    .FIXED_PRI (FIXED_PRI)
  ) u_arb (
    .i_req        ({dma_req_valid, cpu_req_valid}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_in_access  = (r_state == ACCESS);
  assign w_in_resp    = (r_state == RESP);
  assign w_can_accept = (r_state == IDLE) || w_in_resp;

  assign cpu_req_ready = w_can_accept && w_grant[0];
  assign dma_req_ready = w_can_accept && w_grant[1];
  assign w_accept      = cpu_req_ready || dma_req_ready;

  assign w_sel_dma   = w_grant[1];
  assign w_sel_write = w_sel_dma ? dma_req_write : cpu_req_write;
  assign w_sel_addr  = w_sel_dma ? dma_req_addr  : cpu_req_addr;
  assign w_sel_wdata = w_sel_dma ? dma_req_wdata : cpu_req_wdata;
  assign w_sel_err   = addr_err(w_sel_addr, MEM_WORDS);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = w_sel_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        w_next_state = RESP;
      end
      RESP: begin
        if (w_accept) begin
          w_next_state = w_sel_err ? RESP : ACCESS;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Latched transaction and response data
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= c_PORT_DMA;
      r_port       <= c_PORT_CPU;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_err        <= 1'b0;
      r_rdata      <= '0;
    end else if (w_accept) begin
      r_last_grant <= w_sel_dma ? c_PORT_DMA : c_PORT_CPU;
      r_port       <= w_sel_dma ? c_PORT_DMA : c_PORT_CPU;
      r_write      <= w_sel_write;
      r_addr       <= w_sel_addr;
      r_wdata      <= w_sel_wdata;
      r_err        <= w_sel_err;
      // Cleared here so stores and errored requests respond with zero data.
      r_rdata      <= '0;
    end else if (w_in_access && !r_write) begin
      r_rdata <= mem_read_data;
    end
  end

  // --------------------------------------------------------------------------
  // Memory interface: decoded from the state register only, so an async
  // reset in ACCESS removes mem_write before the closing edge.
  // --------------------------------------------------------------------------
  assign mem_read       = w_in_access && !r_write;
  assign mem_write      = w_in_access &&  r_write;
  assign mem_address    = w_in_access ? r_addr  : '0;
  assign mem_write_data = w_in_access ? r_wdata : '0;

  // --------------------------------------------------------------------------
  // Responses
  // --------------------------------------------------------------------------
  assign cpu_rsp_valid = w_in_resp && (r_port == c_PORT_CPU);
  assign cpu_rsp_rdata = cpu_rsp_valid ? r_rdata : '0;
  assign cpu_rsp_err   = cpu_rsp_valid && r_err;

  assign dma_rsp_valid = w_in_resp && (r_port == c_PORT_DMA);
  assign dma_rsp_rdata = dma_rsp_valid ? r_rdata : '0;
  assign dma_rsp_err   = dma_rsp_valid && r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter. A round-robin
//               instance is attached to a behavioural data_memory; a
//               fixed-priority instance shares the request inputs and is used
//               for grant-order checks only.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req_valid, cpu_req_write, dma_req_valid, dma_req_write;
  logic [63:0] cpu_req_addr, cpu_req_wdata, dma_req_addr, dma_req_wdata;

  logic        cpu_req_ready, cpu_rsp_valid, cpu_rsp_err;
  logic        dma_req_ready, dma_rsp_valid, dma_rsp_err;
  logic [63:0] cpu_rsp_rdata, dma_rsp_rdata;
  logic        mem_read, mem_write;
  logic [63:0] mem_address, mem_write_data, mem_read_data;

  logic        f_cpu_req_ready, f_cpu_rsp_valid, f_cpu_rsp_err;
  logic        f_dma_req_ready, f_dma_rsp_valid, f_dma_rsp_err;
  logic [63:0] f_cpu_rsp_rdata, f_dma_rsp_rdata;
  logic        f_mem_read, f_mem_write;
  logic [63:0] f_mem_address, f_mem_write_data;

  logic [63:0] mem [0:1023];

  int n_assert = 0;
  int n_fail   = 0;

  dmem_arbiter #(.FIXED_PRI(0), .MEM_WORDS(1024)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_write(cpu_req_write),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_req_ready(cpu_req_ready), .cpu_rsp_valid(cpu_rsp_valid),
    .cpu_rsp_rdata(cpu_rsp_rdata), .cpu_rsp_err(cpu_rsp_err),
    .dma_req_valid(dma_req_valid), .dma_req_write(dma_req_write),
    .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata),
    .dma_req_ready(dma_req_ready), .dma_rsp_valid(dma_rsp_valid),
    .dma_rsp_rdata(dma_rsp_rdata), .dma_rsp_err(dma_rsp_err),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  dmem_arbiter #(.FIXED_PRI(1), .MEM_WORDS(1024)) u_dut_fp (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_write(cpu_req_write),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_req_ready(f_cpu_req_ready), .cpu_rsp_valid(f_cpu_rsp_valid),
    .cpu_rsp_rdata(f_cpu_rsp_rdata), .cpu_rsp_err(f_cpu_rsp_err),
    .dma_req_valid(dma_req_valid), .dma_req_write(dma_req_write),
    .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata),
    .dma_req_ready(f_dma_req_ready), .dma_rsp_valid(f_dma_rsp_valid),
    .dma_rsp_rdata(f_dma_rsp_rdata), .dma_rsp_err(f_dma_rsp_err),
    .mem_read(f_mem_read), .mem_write(f_mem_write),
    .mem_address(f_mem_address), .mem_write_data(f_mem_write_data),
    .mem_read_data(64'h0)
  );

  // Behavioural data_memory: combinational read, write on posedge.
  assign mem_read_data = mem[mem_address[12:3]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[12:3]] <= mem_write_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; outputs are sampled
  // on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req_valid = 1'b0; cpu_req_write = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
    dma_req_valid = 1'b0; dma_req_write = 1'b0; dma_req_addr = '0; dma_req_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0] = 64'd11;
    mem[1] = 64'd20;
    mem[2] = 64'd30;
    reset = 1'b1;
    idle_inputs();
    do_reset();

    // ---------------- reset state ----------------
    @(negedge clk);
    chk("rst_cpu_ready", {63'd0, cpu_req_ready}, 64'd0);
    chk("rst_dma_ready", {63'd0, dma_req_ready}, 64'd0);
    chk("rst_cpu_rsp",   {63'd0, cpu_rsp_valid}, 64'd0);
    chk("rst_dma_rsp",   {63'd0, dma_rsp_valid}, 64'd0);
    chk("rst_mem_rw",    {62'd0, mem_read, mem_write}, 64'd0);
    chk("rst_mem_addr",  mem_address, 64'd0);

    // ---------------- cpu load 0x8 ----------------
    next_cycle();
    cpu_req_valid = 1'b1; cpu_req_addr = 64'h8;
    @(negedge clk);
    chk("ld_c0_cpu_ready", {63'd0, cpu_req_ready}, 64'd1);
    chk("ld_c0_dma_ready", {63'd0, dma_req_ready}, 64'd0);
    chk("ld_c0_mem_read",  {63'd0, mem_read}, 64'd0);
    next_cycle();
    cpu_req_valid = 1'b0;
    @(negedge clk);
    chk("ld_c1_mem_read",  {63'd0, mem_read}, 64'd1);
    chk("ld_c1_mem_write", {63'd0, mem_write}, 64'd0);
    chk("ld_c1_mem_addr",  mem_address, 64'h8);
    chk("ld_c1_cpu_rsp",   {63'd0, cpu_rsp_valid}, 64'd0);
    chk("ld_c1_dma_rsp",   {63'd0, dma_rsp_valid}, 64'd0);
    next_cycle();
    @(negedge clk);
    chk("ld_c2_cpu_rsp",   {63'd0, cpu_rsp_valid}, 64'd1);
    chk("ld_c2_cpu_rdata", cpu_rsp_rdata, 64'd20);
    chk("ld_c2_cpu_err",   {63'd0, cpu_rsp_err}, 64'd0);
    chk("ld_c2_dma_rsp",   {63'd0, dma_rsp_valid}, 64'd0);
    next_cycle();
    @(negedge clk);
    chk("ld_c3_cpu_rsp",   {63'd0, cpu_rsp_valid}, 64'd0);

    // ---------------- dma store 0x10, then cpu load 0x10 ----------------
    next_cycle();
    dma_req_valid = 1'b1; dma_req_write = 1'b1; dma_req_addr = 64'h10; dma_req_wdata = 64'hDEAD;
    @(negedge clk);
    chk("st_c0_dma_ready", {63'd0, dma_req_ready}, 64'd1);
    next_cycle();
    dma_req_valid = 1'b0; dma_req_write = 1'b0;
    @(negedge clk);
    chk("st_c1_mem_write", {63'd0, mem_write}, 64'd1);
    chk("st_c1_mem_read",  {63'd0, mem_read}, 64'd0);
    chk("st_c1_mem_wdata", mem_write_data, 64'hDEAD);
    chk("st_c1_mem_addr",  mem_address, 64'h10);
    next_cycle();
    cpu_req_valid = 1'b1; cpu_req_write = 1'b0; cpu_req_addr = 64'h10;
    @(negedge clk);
    chk("st_c2_dma_rsp",   {63'd0, dma_rsp_valid}, 64'd1);
    chk("st_c2_dma_rdata", dma_rsp_rdata, 64'd0);
    chk("st_c2_dma_err",   {63'd0, dma_rsp_err}, 64'd0);
    chk("st_c2_cpu_ready", {63'd0, cpu_req_ready}, 64'd1);
    next_cycle();
    cpu_req_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("st_c4_cpu_rsp",   {63'd0, cpu_rsp_valid}, 64'd1);
    chk("st_c4_cpu_rdata", cpu_rsp_rdata, 64'hDEAD);
    next_cycle();

    // ---------------- tie: both ports hold valid loads ----------------
    do_reset();
    cpu_req_valid = 1'b1; cpu_req_addr = 64'h0;
    dma_req_valid = 1'b1; dma_req_addr = 64'h8;
    for (int c = 0; c < 8; c++) begin
      logic [1:0] exp_rr, exp_fp;
      // Accepts land on even cycles: cpu, dma, cpu, dma (round-robin);
      // cpu every time for fixed priority. Encoded as {dma, cpu}.
      exp_rr = (c % 2 != 0) ? 2'b00 : ((c % 4 == 0) ? 2'b01 : 2'b10);
      exp_fp = (c % 2 != 0) ? 2'b00 : 2'b01;
      @(negedge clk);
      chk($sformatf("tie_rr_c%0d", c), {62'd0, dma_req_ready, cpu_req_ready}, {62'd0, exp_rr});
      chk($sformatf("tie_fp_c%0d", c), {62'd0, f_dma_req_ready, f_cpu_req_ready}, {62'd0, exp_fp});
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    chk("tie_last_dma_rsp", {63'd0, dma_rsp_valid}, 64'd1);
    next_cycle();

    // ---------------- error requests ----------------
    do_reset();
    cpu_req_valid = 1'b1; cpu_req_addr = 64'h0C;
    @(negedge clk);
    chk("err_c0_cpu_ready", {63'd0, cpu_req_ready}, 64'd1);
    next_cycle();
    cpu_req_valid = 1'b0;
    dma_req_valid = 1'b1; dma_req_addr = 64'h2000;
    @(negedge clk);
    chk("err_c1_cpu_rsp",   {63'd0, cpu_rsp_valid}, 64'd1);
    chk("err_c1_cpu_err",   {63'd0, cpu_rsp_err}, 64'd1);
    chk("err_c1_cpu_rdata", cpu_rsp_rdata, 64'd0);
    chk("err_c1_mem_rw",    {62'd0, mem_read, mem_write}, 64'd0);
    chk("err_c1_dma_ready", {63'd0, dma_req_ready}, 64'd1);
    next_cycle();
    dma_req_valid = 1'b0;
    @(negedge clk);
    chk("err_c2_dma_rsp",   {63'd0, dma_rsp_valid}, 64'd1);
    chk("err_c2_dma_err",   {63'd0, dma_rsp_err}, 64'd1);
    chk("err_c2_dma_rdata", dma_rsp_rdata, 64'd0);
    chk("err_c2_mem_rw",    {62'd0, mem_read, mem_write}, 64'd0);
    next_cycle();

    // ---------------- back-to-back cpu loads 0x0, 0x10 ----------------
    mem[2] = 64'd30;
    do_reset();
    cpu_req_valid = 1'b1; cpu_req_addr = 64'h0;
    @(negedge clk);
    chk("b2b_c0_ready", {63'd0, cpu_req_ready}, 64'd1);
    next_cycle();
    cpu_req_addr = 64'h10;
    @(negedge clk);
    chk("b2b_c1_ready", {63'd0, cpu_req_ready}, 64'd0);
    next_cycle();
    @(negedge clk);
    chk("b2b_c2_ready", {63'd0, cpu_req_ready}, 64'd1);
    chk("b2b_c2_rsp",   {63'd0, cpu_rsp_valid}, 64'd1);
    chk("b2b_c2_rdata", cpu_rsp_rdata, 64'd11);
    next_cycle();
    cpu_req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_c3_addr",  mem_address, 64'h10);
    chk("b2b_c3_rsp",   {63'd0, cpu_rsp_valid}, 64'd0);
    next_cycle();
    @(negedge clk);
    chk("b2b_c4_rsp",   {63'd0, cpu_rsp_valid}, 64'd1);
    chk("b2b_c4_rdata", cpu_rsp_rdata, 64'd30);
    next_cycle();

    // ---------------- reset during a store ACCESS ----------------
    do_reset();
    dma_req_valid = 1'b1; dma_req_write = 1'b1; dma_req_addr = 64'h18; dma_req_wdata = 64'h55;
    @(negedge clk);
    chk("rst_st_c0_ready", {63'd0, dma_req_ready}, 64'd1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("rst_st_c1_mem_write", {63'd0, mem_write}, 64'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_st_async_mem_write", {63'd0, mem_write}, 64'd0);
    chk("rst_st_async_addr",      mem_address, 64'd0);
    next_cycle();
    @(negedge clk);
    chk("rst_st_no_rsp",    {63'd0, dma_rsp_valid}, 64'd0);
    chk("rst_st_mem3",      mem[3], 64'd0);
    next_cycle();
    reset = 1'b0;
    cpu_req_valid = 1'b1; cpu_req_addr = 64'h0;
    dma_req_valid = 1'b1; dma_req_addr = 64'h8;
    @(negedge clk);
    chk("rst_st_tie", {62'd0, dma_req_ready, cpu_req_ready}, 64'd1);
    chk("rst_st_no_rsp2", {63'd0, dma_rsp_valid}, 64'd0);
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_st_mem3_final", mem[3], 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
